// File: rtl/keypad_if.sv
// Pin-side bundle between the keypad matrix and the scanner.
// The scanner is the master: it drives the rows and reports key events.
interface keypad_if;
  logic [2:0] col_in;
  logic [3:0] row_out;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  modport master (input col_in, output row_out, key_valid, key_code, key_held);
  modport slave  (output col_in, input row_out, key_valid, key_code, key_held);
endinterface

// File: rtl/keypad_scanner.sv
// Row-scanned, debounced 3x4 keypad controller.
// Emits one key_valid pulse per accepted press and tracks the hold until release.
module keypad_scanner #(
  parameter int SCAN_CYCLES = 4,
  parameter int DEBOUNCE    = 3
) (
  input  logic     clk,
  input  logic     reset,
  keypad_if.master kp
);
  localparam int DW = $clog2(SCAN_CYCLES);
  localparam int MW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {S_SCAN, S_DEB, S_HELD} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [MW-1:0]   match_q, match_d, match_inc;
  logic [1:0]      row_q, row_d;
  logic [2:0]      cand_q, cand_d;
  logic [3:0]      code_q, code_d;
  logic            valid_q, valid_d, held_q, held_d;
  logic            sample, accept;

  // Row 0..3 = d..g; column is one-hot with bit 2 = a.
  function automatic logic [3:0] keymap(input logic [1:0] row, input logic [2:0] col);
    logic [3:0] ci;
    ci = col[2] ? 4'd0 : (col[1] ? 4'd1 : 4'd2);
    if (row == 2'd3)
      keymap = (ci == 4'd0) ? 4'hA : ((ci == 4'd1) ? 4'h0 : 4'hB);
    else
      keymap = {2'b00, row} * 4'd3 + ci + 4'd1;
  endfunction

  assign sample    = (dwell_q == DW'(SCAN_CYCLES - 1));
  assign match_inc = match_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_SCAN;
      dwell_q <= '0;
      match_q <= '0;
      row_q   <= 2'd0;
      cand_q  <= 3'b000;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      match_q <= match_d;
      row_q   <= row_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dwell_d = sample ? '0 : dwell_q + 1'b1;
    match_d = match_q;
    row_d   = row_q;
    cand_d  = cand_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    accept  = 1'b0;
    if (sample) begin
      case (state_q)
        S_SCAN: begin
          // Empty or multi-key samples are ambiguous; move on to the next row.
          if ($onehot(kp.col_in)) begin
            cand_d  = kp.col_in;
            match_d = MW'(1);
            state_d = S_DEB;
            if (DEBOUNCE == 1) accept = 1'b1;
          end else begin
            row_d = row_q + 2'd1;
          end
        end
        S_DEB: begin
          if (kp.col_in == cand_q) begin
            match_d = match_inc;
            if (match_inc == MW'(DEBOUNCE)) accept = 1'b1;
          end else begin
            state_d = S_SCAN;
            row_d   = row_q + 2'd1;
            match_d = '0;
          end
        end
        S_HELD: begin
          if (kp.col_in == 3'b000) begin
            if (match_inc == MW'(DEBOUNCE)) begin
              held_d  = 1'b0;
              row_d   = 2'd0;
              state_d = S_SCAN;
              match_d = '0;
            end else begin
              match_d = match_inc;
            end
          end else begin
            match_d = '0;
          end
        end
        default: state_d = S_SCAN;
      endcase
      if (accept) begin
        code_d  = keymap(row_q, cand_d);
        valid_d = 1'b1;
        held_d  = 1'b1;
        state_d = S_HELD;
        match_d = '0;
      end
    end
  end

  assign kp.row_out   = 4'b1000 >> row_q;
  assign kp.key_valid = valid_q;
  assign kp.key_code  = code_q;
  assign kp.key_held  = held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, directed vector table,
// multi-cycle corner sequences and a random run against a sample-level model.
module tb_keypad_scanner;
  localparam int SC  = 4;
  localparam int DEB = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] pressed = '0;   // bit r*3+c, r 0..3 = d..g, c 0..2 = a..c
  logic        force_zero = 1'b0;
  int          cyc = 0;
  int          ntot = 0, npass = 0;
  int          nv = 0, vfirst = -1;
  logic [3:0]  vcode = '0;

  keypad_if kp();
  keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE(DEB)) dut (.clk(clk), .reset(reset), .kp(kp));

  always #5 clk = ~clk;

  // Matrix: a pressed key connects its row drive onto its column line.
  always_comb begin
    logic [2:0] c;
    c = 3'b000;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 3; k++)
        if (pressed[r*3+k] && kp.row_out[3-r]) c[2-k] = 1'b1;
    kp.col_in = force_zero ? 3'b000 : c;
  end

  // Reference model, advanced once per clock edge from the spec's sample rules.
  int keymap [4][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}, '{10, 0, 11}};
  int m_mode, m_row, m_match, m_dwell;  // mode 0 scan, 1 debounce, 2 held
  logic [2:0] m_cand;
  logic [3:0] m_code;
  logic m_valid, m_held;

  task automatic model_step(input logic rs, input logic [2:0] s);
    bit acc;
    if (rs) begin
      m_mode = 0; m_row = 0; m_match = 0; m_dwell = 0; m_cand = 0;
      m_code = 0; m_valid = 0; m_held = 0;
      return;
    end
    m_valid = 0;
    acc = 0;
    if (m_dwell == SC - 1) begin
      if (m_mode == 0) begin
        if ($countones(s) == 1) begin
          m_cand = s; m_match = 1; m_mode = 1;
          if (m_match >= DEB) acc = 1;
        end else m_row = (m_row + 1) % 4;
      end else if (m_mode == 1) begin
        if (s == m_cand) begin
          m_match++;
          if (m_match >= DEB) acc = 1;
        end else begin
          m_mode = 0; m_row = (m_row + 1) % 4; m_match = 0;
        end
      end else begin
        if (s == 0) begin
          m_match++;
          if (m_match >= DEB) begin
            m_held = 0; m_row = 0; m_mode = 0; m_match = 0;
          end
        end else m_match = 0;
      end
      if (acc) begin
        m_code = 4'(keymap[m_row][m_cand[2] ? 0 : (m_cand[1] ? 1 : 2)]);
        m_valid = 1; m_held = 1; m_mode = 2; m_match = 0;
      end
    end
    m_dwell = (m_dwell + 1) % SC;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // One clock: inputs captured before the edge, outputs readable on return.
  task automatic tick();
    logic rs;
    logic [2:0] s;
    @(negedge clk);
    rs = reset;
    s  = kp.col_in;
    @(posedge clk);
    model_step(rs, s);
    #1;
    cyc++;
    if (kp.key_valid) begin
      if (nv == 0) begin vfirst = cyc; vcode = kp.key_code; end
      nv++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cyc = 0; nv = 0; vfirst = -1;
  endtask

  task automatic clr();
    nv = 0; vfirst = -1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic [11:0] mask;
    int          exp_cyc;   // -1: no event expected
    int          exp_code;
  } vec_t;

  vec_t tbl [15];
  int   pick, hold_cnt;
  logic prev_v;

  initial begin
    tbl[0]  = '{12'h001, 12, 1};   tbl[1]  = '{12'h002, 12, 2};
    tbl[2]  = '{12'h004, 12, 3};   tbl[3]  = '{12'h008, 16, 4};
    tbl[4]  = '{12'h010, 16, 5};   tbl[5]  = '{12'h020, 16, 6};
    tbl[6]  = '{12'h040, 20, 7};   tbl[7]  = '{12'h080, 20, 8};
    tbl[8]  = '{12'h100, 20, 9};   tbl[9]  = '{12'h200, 24, 10};
    tbl[10] = '{12'h400, 24, 0};   tbl[11] = '{12'h800, 24, 11};
    tbl[12] = '{12'h140, -1, 0};   tbl[13] = '{12'h003, -1, 0};
    tbl[14] = '{12'h011, 12, 1};

    // Directed table: each key held from reset release.
    for (int i = 0; i < 15; i++) begin
      pressed = 12'h000;
      do_reset();
      chk("rst_row", int'(kp.row_out), 8);
      chk("rst_state", int'({kp.key_valid, kp.key_code, kp.key_held}), 0);
      pressed = tbl[i].mask;
      run_to(3);
      chk("row_d_dwell", int'(kp.row_out), 8);
      run_to(80);
      chk($sformatf("n_events[%0d]", i), nv, (tbl[i].exp_cyc >= 0) ? 1 : 0);
      chk($sformatf("event_cyc[%0d]", i), vfirst, tbl[i].exp_cyc);
      if (tbl[i].exp_cyc >= 0) chk($sformatf("event_code[%0d]", i), int'(vcode), tbl[i].exp_code);
      chk($sformatf("held[%0d]", i), int'(kp.key_held), (tbl[i].exp_cyc >= 0) ? 1 : 0);
    end

    // Key 5: release at cycle 20, zero samples at 23/27/31.
    pressed = 12'h000; do_reset(); pressed = 12'h010;
    run_to(20);
    chk("k5_cyc", vfirst, 16);
    pressed = 12'h000;
    run_to(31);
    chk("k5_held_31", int'(kp.key_held), 1);
    chk("k5_row_31", int'(kp.row_out), 4);
    run_to(32);
    chk("k5_held_32", int'(kp.key_held), 0);
    chk("k5_row_32", int'(kp.row_out), 8);

    // Key 0 with one bounced debounce sample at cycle 19.
    pressed = 12'h000; do_reset(); pressed = 12'h400;
    run_to(19);
    force_zero = 1'b1;
    run_to(20);
    force_zero = 1'b0;
    chk("bounce_row", int'(kp.row_out), 8);
    chk("bounce_nv", nv, 0);
    run_to(50);
    chk("bounce_cyc", vfirst, 44);
    chk("bounce_code", int'(vcode), 0);
    chk("bounce_held", int'(kp.key_held), 1);

    // 7+9 together, then release 9.
    pressed = 12'h000; do_reset(); pressed = 12'h140;
    run_to(200);
    chk("multi_nv", nv, 0);
    clr(); pressed = 12'h040;
    run(80);
    chk("multi_rel_nv", nv, 1);
    chk("multi_rel_code", int'(vcode), 7);

    // # held, then 3 added, release both, press 3 again.
    pressed = 12'h000; do_reset(); pressed = 12'h800;
    run_to(60);
    chk("hash_code", int'(vcode), 11);
    clr(); pressed = 12'h804;
    run(100);
    chk("second_key_nv", nv, 0);
    chk("second_key_held", int'(kp.key_held), 1);
    pressed = 12'h000;
    run(20);
    chk("both_rel_held", int'(kp.key_held), 0);
    clr(); pressed = 12'h004;
    run(60);
    chk("k3_nv", nv, 1);
    chk("k3_code", int'(vcode), 3);

    // Reset during HELD and during DEBOUNCE, key kept pressed.
    pressed = 12'h000; do_reset(); pressed = 12'h001;
    run_to(14);
    do_reset();
    chk("rst_held_row", int'(kp.row_out), 8);
    chk("rst_held_outs", int'({kp.key_valid, kp.key_code, kp.key_held}), 0);
    run_to(30);
    chk("rst_held_retrig", vfirst, 12);
    pressed = 12'h000; do_reset(); pressed = 12'h001;
    run_to(8);
    do_reset();
    chk("rst_deb_row", int'(kp.row_out), 8);
    chk("rst_deb_outs", int'({kp.key_valid, kp.key_code, kp.key_held}), 0);
    run_to(30);
    chk("rst_deb_retrig", vfirst, 12);
    chk("rst_deb_nv", nv, 1);

    // Random presses, bounces and resets against the reference model.
    pressed = 12'h000; do_reset();
    hold_cnt = 0; prev_v = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      chk("rand_outs", int'({kp.row_out, kp.key_valid, kp.key_code, kp.key_held}),
          int'({4'(4'b1000 >> m_row), m_valid, m_code, m_held}));
      if (kp.key_valid) chk("rand_valid_consec", int'(prev_v), 0);
      prev_v = kp.key_valid;
      if (hold_cnt == 0) begin
        pick = int'($urandom_range(0, 99));
        if (pick < 40) pressed = 12'h000;
        else if (pick < 85) pressed = 12'h001 << $urandom_range(0, 11);
        else pressed = (12'h001 << $urandom_range(0, 11)) | (12'h001 << $urandom_range(0, 11));
        hold_cnt = int'($urandom_range(10, 120));
      end else hold_cnt--;
      force_zero = ($urandom_range(0, 29) == 0);
      reset      = ($urandom_range(0, 799) == 0);
      tick();
    end
    force_zero = 1'b0;
    reset = 1'b0;

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Sequential scan controller for the 3-column x 4-row keypad matrix.
- Drives one row line at a time and samples the three column lines.
- Debounces the sampled columns, then emits one key event per press as a 4-bit code with a single-cycle valid strobe.
- Sits between the physical keypad pins and downstream logic such as code-entry and display blocks. It replaces the combinational decode with a scanned, debounced event source.

Parameters:
- SCAN_CYCLES, 4, clock cycles each row is driven before its columns are sampled (must be >= 2).
- DEBOUNCE, 3, consecutive identical samples required to accept a press or a release (must be >= 1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- col_in  input  3  column lines {a,b,c}; bit 2 = a (left), bit 0 = c (right); 1 = contact.
- row_out  output  4  one-hot row drive {d,e,f,g}; bit 3 = d (top), bit 0 = g (bottom).
- key_valid  output  1  one-cycle pulse when a debounced press is accepted.
- key_code  output  4  code of last accepted key; held until the next accept.
- key_held  output  1  high while the accepted key remains pressed, until release is debounced.

Behaviour:
- Key map, by (row, col a/b/c):
  - d: 1, 2, 3
  - e: 4, 5, 6
  - f: 7, 8, 9
  - g: 0xA (*), 0x0, 0xB (#)
- Reset, synchronous, takes priority over everything:
  - row_out=4'b1000 (row d), key_valid=0, key_code=4'h0, key_held=0.
  - State SCAN; dwell counter=0; match counter=0.
  - Reset asserted mid-press aborts the press with no event. After reset, a still-pressed key is re-detected from scratch.
- Dwell counter: counts 0..SCAN_CYCLES-1 and wraps in every state. A "sample" is col_in captured at the edge where dwell==SCAN_CYCLES-1.
- State SCAN:
  - Sample result 000, or more than one bit set (multi-key): reject. Rotate row_out d->e->f->g->d on the same edge.
  - Sample result exactly one bit set: latch the candidate column. Hold the current row, set match=1, go to DEBOUNCE.
  - If DEBOUNCE==1, accept immediately (see below).
- State DEBOUNCE:
  - Row held. On each sample, a result equal to the candidate increments match.
  - Any other result, including 000: go to SCAN, advance to the next row, no event.
  - When match reaches DEBOUNCE, accept:
    - key_code updated and key_valid=1 for exactly the next cycle.
    - key_held=1 from that cycle.
    - Go to HELD, match=0.
- State HELD:
  - Row held. A sample of 000 increments match; any nonzero sample resets match to 0.
  - When match reaches DEBOUNCE: key_held=0 on the next cycle, row_out=row d, go to SCAN, match=0.
  - A different key pressed during HELD produces no event.
- Latency, defaults, key held from reset release (cycle 0 = first cycle with reset low):
  - Row d samples at the end of cycles 3, 7, 11.
  - key_valid is high in cycle 12 for key 1.
  - Each row later in the scan order adds 4 cycles to the first sample.
- key_valid never asserts on two consecutive cycles. At most one event is produced per press.

Test Plan:
- The bench models the matrix as col_in[c] = row_out[r] for each pressed key (r,c), combinationally.
1. Reset, then hold key 1 (row d, col a) from cycle 0 -> row_out=1000 in cycles 0-3; key_valid=1 only in cycle 12; key_code=1; key_held=1 from cycle 12.
2. Hold key 5 (row e, col b) from cycle 0 -> samples at 7, 11, 15; key_valid in cycle 16; key_code=5. Then release -> key_held falls the cycle after the third all-zero sample; row_out returns to 1000.
3. Press key 0 (row g, col b) with col_in forced to 000 for only the second debounce sample (bounce) -> no key_valid on that attempt; row_out advances to 1000. On the next pass, key_valid with key_code=0.
4. Press 7 and 9 together (row f, cols a+c) -> col_in=101 on row f, rejected; key_valid stays 0 for 200 cycles. Release 9 -> key_valid once with key_code=7.
5. Press # (row g, col c) -> key_code=0xB. Press and hold 3 while # is still held -> no second event. Release both -> key_held=0. Press 3 again -> key_valid with key_code=3.
6. Assert reset for 1 cycle during HELD and during DEBOUNCE -> next cycle row_out=1000, key_held=0, key_code=0, no key_valid. A still-held key re-triggers after the full debounce latency.
